// File: rtl/pyth_check_seq_if.sv
// Triple/result stream between a config loader (master) and the right-triangle checker (slave).
// The parameter WIDTH must match the checker's WIDTH.
interface pyth_check_seq_if #(
    parameter int WIDTH = 8
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic [WIDTH-1:0]     in_c;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_match;
    logic [2*WIDTH:0]     out_sum;
    logic [2*WIDTH-1:0]   out_csq;

    modport master (
        output in_valid, in_a, in_b, in_c, out_ready,
        input  in_ready, out_valid, out_match, out_sum, out_csq
    );

    modport slave (
        input  in_valid, in_a, in_b, in_c, out_ready,
        output in_ready, out_valid, out_match, out_sum, out_csq
    );
endinterface

// File: rtl/pyth_check_seq.sv
// Sequential a^2+b^2==c^2 checker: three bit-serial shift-add squarers feeding one compare.
// Optional PYTH_CHECK_STATS_EN adds saturating pass/fail counters.
module pyth_check_seq #(
    parameter int WIDTH = 8,
    parameter int DEF_A = 3,
    parameter int DEF_B = 4,
    parameter int DEF_C = 5,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pyth_check_seq_if.slave      bus
`ifdef PYTH_CHECK_STATS_EN
    ,
    output logic [CNT_W-1:0]     pass_cnt,
    output logic [CNT_W-1:0]     fail_cnt
`endif
);
    localparam int SQ_W  = 2 * WIDTH;
    localparam int SUM_W = 2 * WIDTH + 1;
    localparam int BIT_W = $clog2(WIDTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] CMP  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("pyth_check_seq: WIDTH=%0d outside 2..32", WIDTH);
        end
        if (DEF_A * DEF_A + DEF_B * DEF_B != DEF_C * DEF_C) begin : g_bad_default
            $error("pyth_check_seq: %0d,%0d,%0d is not a right triangle", DEF_A, DEF_B, DEF_C);
        end
        if (CNT_W < 1) begin : g_bad_cnt
            $error("pyth_check_seq: CNT_W=%0d must be positive", CNT_W);
        end
    endgenerate

    logic [1:0]        state;
    logic [BIT_W-1:0]  bit_cnt;
    logic [WIDTH-1:0]  mp_a, mp_b, mp_c;
    logic [SQ_W-1:0]   sh_a, sh_b, sh_c;
    logic [SQ_W-1:0]   acc_a, acc_b, acc_c;
    logic [SUM_W-1:0]  sum_q;
    logic [SQ_W-1:0]   csq_q;
    logic              match_q;
    logic [SUM_W-1:0]  sum_ab;
    logic              handshake;

    assign sum_ab    = SUM_W'(acc_a) + SUM_W'(acc_b);
    assign handshake = (state == DONE) && bus.out_ready;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_match = match_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_csq   = csq_q;

    // Multiplicands shift left and multipliers shift right, so each step only tests bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            mp_a    <= '0;
            mp_b    <= '0;
            mp_c    <= '0;
            sh_a    <= '0;
            sh_b    <= '0;
            sh_c    <= '0;
            acc_a   <= '0;
            acc_b   <= '0;
            acc_c   <= '0;
            sum_q   <= '0;
            csq_q   <= '0;
            match_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        mp_a    <= bus.in_a;
                        mp_b    <= bus.in_b;
                        mp_c    <= bus.in_c;
                        sh_a    <= SQ_W'(bus.in_a);
                        sh_b    <= SQ_W'(bus.in_b);
                        sh_c    <= SQ_W'(bus.in_c);
                        acc_a   <= '0;
                        acc_b   <= '0;
                        acc_c   <= '0;
                        bit_cnt <= '0;
                        state   <= MUL;
                    end
                end
                MUL: begin
                    if (mp_a[0]) acc_a <= acc_a + sh_a;
                    if (mp_b[0]) acc_b <= acc_b + sh_b;
                    if (mp_c[0]) acc_c <= acc_c + sh_c;
                    sh_a    <= sh_a << 1;
                    sh_b    <= sh_b << 1;
                    sh_c    <= sh_c << 1;
                    mp_a    <= mp_a >> 1;
                    mp_b    <= mp_b >> 1;
                    mp_c    <= mp_c >> 1;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) state <= CMP;
                end
                CMP: begin
                    sum_q   <= sum_ab;
                    csq_q   <= acc_c;
                    match_q <= ({1'b0, acc_c} == sum_ab);
                    state   <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PYTH_CHECK_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (handshake) begin
            if (match_q) begin
                if (pass_cnt != {CNT_W{1'b1}}) pass_cnt <= pass_cnt + 1'b1;
            end else begin
                if (fail_cnt != {CNT_W{1'b1}}) fail_cnt <= fail_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_handshake;
    assign unused_handshake = handshake;
`endif
endmodule

// File: tb/tb_pyth_check_seq.sv
// Directed bench for pyth_check_seq at WIDTH=8; stats checks run when PYTH_CHECK_STATS_EN is defined.
module tb_pyth_check_seq;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pyth_check_seq_if #(.WIDTH(WIDTH)) bus ();

`ifdef PYTH_CHECK_STATS_EN
    logic [1:0] pass_cnt;
    logic [1:0] fail_cnt;
    pyth_check_seq #(.WIDTH(WIDTH), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
    );
`else
    pyth_check_seq #(.WIDTH(WIDTH), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        int t = 0;
        while (!bus.in_ready && t < 50) begin
            tick();
            t++;
        end
        check("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
        bus.in_a = a;
        bus.in_b = b;
        bus.in_c = c;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    // Full transaction with the consumer always ready.
    task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input int exp_sum, input int exp_csq,
                       input logic exp_match);
        int lat;
        bus.out_ready = 1'b1;
        accept(a, b, c);
        wait_valid(lat);
        check({tag, "_latency"}, 64'(lat), 64'd9);
        check({tag, "_sum"},     64'(bus.out_sum), 64'(exp_sum));
        check({tag, "_csq"},     64'(bus.out_csq), 64'(exp_csq));
        check({tag, "_match"},   64'(bus.out_match), 64'(exp_match));
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_consumed"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        int lat;
        int extra;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.in_c     = '0;
        bus.out_ready = 1'b0;
        repeat (2) tick();
        check("rst_in_ready",  64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_match",     64'(bus.out_match), 64'd0);
        check("rst_sum",       64'(bus.out_sum), 64'd0);
        check("rst_csq",       64'(bus.out_csq), 64'd0);
        rst_n = 1'b1;
        tick();

        // 3-4-5 with consumer ready; in_ready returns right after the consuming edge.
        run("t345", 8'd3, 8'd4, 8'd5, 25, 25, 1'b1);
        check("t345_in_ready_back", 64'(bus.in_ready), 64'd1);

        // 5-12-13 with back-pressure for five cycles.
        accept(8'd5, 8'd12, 8'd13);
        wait_valid(lat);
        check("t51213_latency", 64'(lat), 64'd9);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", 64'(bus.out_valid), 64'd1);
            check("stall_sum",   64'(bus.out_sum), 64'd169);
            check("stall_csq",   64'(bus.out_csq), 64'd169);
            check("stall_match", 64'(bus.out_match), 64'd1);
            check("stall_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("t51213_consumed", 64'(bus.out_valid), 64'd0);
        check("t51213_sum_kept", 64'(bus.out_sum), 64'd169);
        check("t51213_in_ready", 64'(bus.in_ready), 64'd1);

        run("all_ones", 8'd255, 8'd255, 8'd255, 130050, 65025, 1'b0);
        run("all_zero", 8'd0, 8'd0, 8'd0, 0, 0, 1'b1);

        // in_valid held high with changing data while the triple is in flight.
        bus.in_a = 8'd3;
        bus.in_b = 8'd4;
        bus.in_c = 8'd5;
        bus.in_valid = 1'b1;
        tick();
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            bus.in_a = 8'(lat + 7);
            bus.in_b = 8'(lat * 3 + 1);
            bus.in_c = 8'(200 - lat);
            tick();
            lat++;
        end
        bus.in_valid = 1'b0;
        check("hold_latency", 64'(lat), 64'd9);
        check("hold_sum",     64'(bus.out_sum), 64'd25);
        check("hold_csq",     64'(bus.out_csq), 64'd25);
        check("hold_match",   64'(bus.out_match), 64'd1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        extra = 0;
        repeat (15) begin
            tick();
            if (bus.out_valid) extra++;
        end
        check("hold_single_result", 64'(extra), 64'd0);

        // Reset pulse during MUL step 3 discards the triple.
        accept(8'd7, 8'd24, 8'd25);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready",  64'(bus.in_ready), 64'd1);
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_sum",       64'(bus.out_sum), 64'd0);
        check("midrst_csq",       64'(bus.out_csq), 64'd0);
        check("midrst_match",     64'(bus.out_match), 64'd0);
        tick();
        rst_n = 1'b1;
        extra = 0;
        repeat (15) begin
            tick();
            if (bus.out_valid) extra++;
        end
        check("midrst_no_result", 64'(extra), 64'd0);
        check("midrst_idle",      64'(bus.in_ready), 64'd1);
        run("t6810", 8'd6, 8'd8, 8'd10, 100, 100, 1'b1);

`ifdef PYTH_CHECK_STATS_EN
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("stats_rst_pass", 64'(pass_cnt), 64'd0);
        check("stats_rst_fail", 64'(fail_cnt), 64'd0);
        for (int i = 0; i < 5; i++) run("stats_pass", 8'd3, 8'd4, 8'd5, 25, 25, 1'b1);
        for (int i = 0; i < 2; i++) run("stats_fail", 8'd2, 8'd2, 8'd2, 8, 4, 1'b0);
        check("stats_pass_sat", 64'(pass_cnt), 64'd3);
        check("stats_fail",     64'(fail_cnt), 64'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
